vga_tile_pixel_source: RTL and testbench
========================================

Name: vga_tile_pixel_source

Overview:
- Pixel-stream transmitter for the HDMI display path.
- Generates 640x480@60 timing (800x525 total) on pixel_clk.
- Fetches a 20x15 tile map of 32x32-pixel tiles from the game state RAM and sprite pixels from the sprite ROM, maps 4-bit colour indices through a 16-entry palette, and drives rgb/hsync/vsync/vde/drawX/drawY for the HDMI encoder and the simulation bitmap logger.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

Ports:
- pixel_clk  in  1  pixel clock (25 MHz)
- arstn  in  1  reset, synchronous, active-low
- map_addr  out  9  tile map RAM read address (0..299)
- map_rdata  in  8  map word, valid 1 cycle after map_addr: [5:0] sprite_id, [6] hflip, [7] hide
- rom_addr  out  16  sprite ROM address {sprite_id, row[4:0], col[4:0]}
- rom_rdata  in  4  colour index, valid 1 cycle after rom_addr
- pal_we  in  1  palette write enable
- pal_idx  in  4  palette entry to write
- pal_data  in  12  {R,G,B} 4 bits each
- bg_color  in  12  colour for index 0 or hidden tiles
- red, green, blue  out  4 each  pixel colour
- hsync, vsync  out  1 each  active-low sync
- vde  out  1  video data enable
- drawX, drawY  out  10 each  coordinates of the pixel currently on rgb
- vblank_start  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
Reset (arstn sampled low on a pixel_clk edge):
- hc = vc = 0.
- Outputs: rgb = 0, hsync = vsync = 1, vde = 0, drawX = drawY = 0, map_addr = 0, rom_addr = 0, vblank_start = 0.
- Palette entry i resets to {i,i,i} (grayscale).
- Pipeline valid bits are cleared. A reset mid-frame restarts the frame at (0,0) with no stale pixels emitted.

Counters (stage S0):
- hc counts 0..799; it wraps to 0 and increments vc.
- vc counts 0..524 and wraps to 0 after the last pixel of line 524.
- raw_vde = (hc < 640) && (vc < 480).
- raw_hs low for hc in 656..751; raw_vs low for vc in 490..491.
- vblank_start = 1 for exactly one cycle when hc == 0 && vc == 480 (counter-aligned, not delayed).

Pipeline (all stages registered):
- S1: map_addr = vc[9:5]*20 + hc[9:5], computed as (y<<4)+(y<<2)+x. map_addr = 0 when raw_vde = 0.
- S2: map_rdata is valid. rom_addr = {sprite_id, vc[4:0], hflip ? ~hc[4:0] : hc[4:0]}, using delayed copies of hc/vc. The hide bit is carried forward.
- S3: rom_rdata is valid. colour = (hide || rom_rdata == 0) ? bg_color : palette[rom_rdata].
- S4: rgb is registered. If vde = 0, rgb = 0.

Alignment and latency:
- Total latency is 4 cycles from counter to rgb.
- hsync, vsync, vde, drawX and drawY are delayed through a matching 4-stage shift so all outputs describe the same pixel.

Palette:
- Written on pixel_clk when pal_we = 1.
- A write and an S3 read of the same entry in the same cycle returns the old value. The new value is visible from the next cycle.

Timing:
- Line period is 800 cycles; frame period is 420000 cycles.
- After reset release, the first vde = 1 appears on the 5th rising edge with drawX = 0, drawY = 0.

Decomposition:
- Package vga_tile_pkg holds:
  - the timing localparams and derived totals (H_TOTAL = 800, V_TOTAL = 525);
  - map word field positions;
  - TILE_BITS = 5, MAP_W = 20, MAP_H = 15;
  - typedef rgb12_t (packed struct r/g/b, 4 bits each);
  - typedef map_word_t.
- Sub-module vga_timing_counter provides hc, vc, raw_hs, raw_vs, raw_vde and vblank_start.
- The fetch pipeline and palette stay in the top-level block.

Test Plan:
- Reset and first pixel: hold arstn low 4 cycles, then release.
  - During reset all outputs hold their reset values.
  - vde first rises on edge 5 with drawX = 0, drawY = 0.
  - Palette index 7 with map/ROM returning index 7 gives rgb = 7,7,7.
- Sync timing:
  - hsync low for exactly 96 cycles, beginning when the delayed drawX = 656; hsync edges are 800 cycles apart.
  - vsync low during lines 490–491.
  - vblank_start pulses once per 420000 cycles.
- Tile fetch: map model returns 8'h03 at addr 21; ROM model returns 5 for sprite 3; palette[5] = 12'hF80.
  - Pixels x 32..63, y 32..63 output R = F, G = 8, B = 0.
  - Observed rom_addr = {6'd3, row, col}.
- hflip and hide:
  - Map word 8'h43 gives rom_addr col field = 31 - (x mod 32).
  - Map word 8'h83 outputs bg_color = 12'h00F regardless of rom_rdata.
  - rom_rdata = 0 also outputs bg_color.
- Palette write collision:
  - pal_we with idx 5, data 12'h0F0 in the same cycle an S3 lookup reads entry 5: that pixel shows the old value, the next pixel shows 0,F,0.
- Reset mid-frame: assert arstn low at vc = 200, hc = 300 for 1 cycle.
  - vde = 0 and rgb = 0 for the following 4 cycles.
  - Output then resumes at drawX = 0, drawY = 0.

Source files
------------

// File: rtl/vga_tile_pixel_source_pkg.sv
// vga_tile_pkg -- shared timing constants, map word layout and pixel types for the tile pixel source.
// rev 1.0
`default_nettype none

package vga_tile_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;

  localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int TILE_BITS    = 5;
  localparam int MAP_W        = 20;
  localparam int MAP_H        = 15;
  localparam int MAP_HIDE_BIT = 7;
  localparam int MAP_FLIP_BIT = 6;
  localparam int SPRITE_ID_W  = 6;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic                   hide;
    logic                   hflip;
    logic [SPRITE_ID_W-1:0] sprite_id;
  } map_word_t;

  // Per-pixel sideband carried alongside the fetch pipeline.
  typedef struct packed {
    logic       vde;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [9:0] y;
  } px_tag_t;

  localparam px_tag_t TAG_IDLE = '{vde: 1'b0, hs: 1'b1, vs: 1'b1, x: 10'd0, y: 10'd0};

endpackage

`default_nettype wire

// File: rtl/vga_tile_pixel_source_if.sv
// vga_tile_pixel_source_if -- read bus to the tile map RAM and sprite ROM.
// rev 1.0
`default_nettype none

interface vga_tile_pixel_source_if;
  logic [8:0]  map_addr;
  logic [7:0]  map_rdata;
  logic [15:0] rom_addr;
  logic [3:0]  rom_rdata;

  modport master (output map_addr, output rom_addr, input map_rdata, input rom_rdata);
  modport slave  (input map_addr, input rom_addr, output map_rdata, output rom_rdata);
endinterface

`default_nettype wire

// File: rtl/vga_tile_pixel_source_timing.sv
// vga_timing_counter -- 800x525 raster counters with raw sync/enable decode.
// rev 1.0
`default_nettype none

module vga_timing_counter
  import vga_tile_pkg::*;
(
  input  wire logic       pixel_clk,
  input  wire logic       arstn,
  output logic      [9:0] o_hc,
  output logic      [9:0] o_vc,
  output logic            o_raw_hs,
  output logic            o_raw_vs,
  output logic            o_raw_vde,
  output logic            o_vblank_start
);

  logic       r_run;
  logic [9:0] r_hc;
  logic [9:0] r_vc;

  // r_run holds the counters at (0,0) for one cycle after reset so pixel 0
  // enters the pipeline together with its valid bit.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      r_run <= 1'b0;
      r_hc  <= 10'd0;
      r_vc  <= 10'd0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (r_hc == H_TOTAL - 10'd1) begin
          r_hc <= 10'd0;
          r_vc <= (r_vc == V_TOTAL - 10'd1) ? 10'd0 : r_vc + 10'd1;
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  assign o_hc           = r_hc;
  assign o_vc           = r_vc;
  assign o_raw_vde      = r_run && (r_hc < H_ACTIVE) && (r_vc < V_ACTIVE);
  assign o_raw_hs       = !((r_hc >= H_ACTIVE + H_FP) && (r_hc < H_ACTIVE + H_FP + H_SYNC));
  assign o_raw_vs       = !((r_vc >= V_ACTIVE + V_FP) && (r_vc < V_ACTIVE + V_FP + V_SYNC));
  assign o_vblank_start = r_run && (r_hc == 10'd0) && (r_vc == V_ACTIVE);

endmodule

`default_nettype wire

// File: rtl/vga_tile_pixel_source.sv
// vga_tile_pixel_source -- 640x480 tile/sprite pixel stream with palette, 4-cycle fetch pipeline.
// rev 1.0
`default_nettype none

module vga_tile_pixel_source
  import vga_tile_pkg::*;
(
  input  wire logic                        pixel_clk,
  input  wire logic                        arstn,
  vga_tile_pixel_source_if.master          mem,
  input  wire logic                        pal_we,
  input  wire logic                 [3:0]  pal_idx,
  input  wire logic                 [11:0] pal_data,
  input  wire logic                 [11:0] bg_color,
  output logic                      [3:0]  red,
  output logic                      [3:0]  green,
  output logic                      [3:0]  blue,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             vde,
  output logic                      [9:0]  drawX,
  output logic                      [9:0]  drawY,
  output logic                             vblank_start
);

  logic [9:0]  w_hc;
  logic [9:0]  w_vc;
  logic        w_hs;
  logic        w_vs;
  logic        w_vde;
  logic [8:0]  w_map_addr;
  logic [4:0]  w_col;
  map_word_t   w_map;

  px_tag_t     r_tag [1:4];
  logic [8:0]  r_map_addr;
  logic [15:0] r_rom_addr;
  logic        r_hide;
  logic [11:0] r_color;
  rgb12_t      r_rgb;
  logic [11:0] r_pal [16];

  vga_timing_counter u_timing (
    .pixel_clk      (pixel_clk),
    .arstn          (arstn),
    .o_hc           (w_hc),
    .o_vc           (w_vc),
    .o_raw_hs       (w_hs),
    .o_raw_vs       (w_vs),
    .o_raw_vde      (w_vde),
    .o_vblank_start (vblank_start)
  );

  // Tile index = row*20 + col, built from shifts so no multiplier is needed.
  assign w_map_addr = ({4'd0, w_vc[9:5]} << 4) + ({4'd0, w_vc[9:5]} << 2) + {4'd0, w_hc[9:5]};
  assign w_map      = mem.map_rdata;
  assign w_col      = w_map.hflip ? ~r_tag[1].x[4:0] : r_tag[1].x[4:0];

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      for (int i = 1; i <= 4; i++) begin
        r_tag[i] <= TAG_IDLE;
      end
      r_map_addr <= 9'd0;
      r_rom_addr <= 16'd0;
      r_hide     <= 1'b0;
      r_color    <= 12'd0;
      r_rgb      <= '0;
    end else begin
      r_tag[1]   <= '{vde: w_vde, hs: w_hs, vs: w_vs, x: w_hc, y: w_vc};
      r_tag[2]   <= r_tag[1];
      r_tag[3]   <= r_tag[2];
      r_tag[4]   <= r_tag[3];
      r_map_addr <= w_vde ? w_map_addr : 9'd0;
      r_rom_addr <= {w_map.sprite_id, r_tag[1].y[4:0], w_col};
      r_hide     <= w_map.hide;
      r_color    <= (r_hide || (mem.rom_rdata == 4'd0)) ? bg_color : r_pal[mem.rom_rdata];
      r_rgb      <= r_tag[3].vde ? rgb12_t'(r_color) : '0;
    end
  end

  // Lookup above reads the pre-write entry, so a same-cycle write shows up one pixel later.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      for (int i = 0; i < 16; i++) begin
        r_pal[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_data;
    end
  end

  assign mem.map_addr = r_map_addr;
  assign mem.rom_addr = r_rom_addr;
  assign red          = r_rgb.r;
  assign green        = r_rgb.g;
  assign blue         = r_rgb.b;
  assign hsync        = r_tag[4].hs;
  assign vsync        = r_tag[4].vs;
  assign vde          = r_tag[4].vde;
  assign drawX        = r_tag[4].x;
  assign drawY        = r_tag[4].y;

endmodule

`default_nettype wire

// File: tb/tb_vga_tile_pixel_source.sv
// tb_vga_tile_pixel_source -- randomized self-checking bench with a per-pixel reference model.
// rev 1.0
`default_nettype none

module tb_vga_tile_pixel_source;

  logic        pixel_clk = 1'b0;
  logic        arstn     = 1'b0;
  logic        pal_we    = 1'b0;
  logic [3:0]  pal_idx   = 4'd0;
  logic [11:0] pal_data  = 12'd0;
  logic [11:0] bg_color  = 12'h00F;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, vde, vblank_start;
  logic [9:0]  drawX, drawY;

  logic [7:0]  map_mem [0:511];
  logic [3:0]  rom_mem [0:65535];
  logic [11:0] pal_m   [16];

  int n_cmp = 0;
  int n_bad = 0;

  vga_tile_pixel_source_if mem_if ();

  assign mem_if.map_rdata = map_mem[mem_if.map_addr];
  assign mem_if.rom_rdata = rom_mem[mem_if.rom_addr];

  vga_tile_pixel_source dut (
    .pixel_clk    (pixel_clk),
    .arstn        (arstn),
    .mem          (mem_if),
    .pal_we       (pal_we),
    .pal_idx      (pal_idx),
    .pal_data     (pal_data),
    .bg_color     (bg_color),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync        (hsync),
    .vsync        (vsync),
    .vde          (vde),
    .drawX        (drawX),
    .drawY        (drawY),
    .vblank_start (vblank_start)
  );

  always #20 pixel_clk = ~pixel_clk;

  // Colour a pixel must show, straight from the tile/sprite/palette rules.
  function automatic logic [11:0] model_rgb(input int x, input int y);
    logic [7:0] w;
    logic [3:0] idx;
    int         col;
    w   = map_mem[(y / 32) * 20 + x / 32];
    col = w[6] ? 31 - (x % 32) : x % 32;
    idx = rom_mem[int'(w[5:0]) * 1024 + (y % 32) * 32 + col];
    if (w[7] || idx == 4'd0) return bg_color;
    return pal_m[idx];
  endfunction

  task automatic pal_reset_model();
    for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
  endtask

  task automatic wait_pix(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 430000; i++) begin
      @(negedge pixel_clk);
      if (drawX == 10'(x) && drawY == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pal_write(input logic [3:0] idx, input logic [11:0] data);
    pal_idx  = idx;
    pal_data = data;
    pal_we   = 1'b1;
    @(posedge pixel_clk);
    #1 pal_we = 1'b0;
    pal_m[idx] = data;
  endtask

  task automatic test_reset();
    logic [7:0]  map_exp;
    arstn = 1'b0;
    pal_reset_model();
    repeat (4) begin
      @(negedge pixel_clk);
      n_cmp++;
      if ({red, green, blue, hsync, vsync, vde, drawX, drawY, mem_if.map_addr, mem_if.rom_addr, vblank_start}
          !== {12'h000, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 16'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_state: rgb=%h hs=%b vs=%b vde=%b x=%0d y=%0d ma=%0d ra=%h vb=%b, want all idle",
                 {red, green, blue}, hsync, vsync, vde, drawX, drawY, mem_if.map_addr, mem_if.rom_addr, vblank_start);
      end
    end
    arstn = 1'b1;
    map_exp = map_mem[0];
    for (int e = 1; e <= 5; e++) begin
      @(negedge pixel_clk);
      n_cmp++;
      if (e < 5) begin
        if (vde !== 1'b0) begin
          n_bad++;
          $display("FAIL first_pixel_early: edge %0d vde=%b want 0", e, vde);
        end
      end else if ({vde, drawX, drawY, red, green, blue} !== {1'b1, 10'd0, 10'd0, 12'h777}) begin
        n_bad++;
        $display("FAIL first_pixel: vde=%b x=%0d y=%0d rgb=%h want vde=1 x=0 y=0 rgb=777 (map0=%h)",
                 vde, drawX, drawY, {red, green, blue}, map_exp);
      end
    end
  endtask

  task automatic test_sync();
    int ex, ey, last_fall;
    logic prev_hs, exp_hs;
    prev_hs   = hsync;
    last_fall = -1;
    for (int c = 1; c <= 2400; c++) begin
      @(negedge pixel_clk);
      ex     = c % 800;
      ey     = c / 800;
      exp_hs = !(ex >= 656 && ex < 752);
      n_cmp++;
      if ({drawX, drawY, vde, hsync, vsync, vblank_start} !==
          {10'(ex), 10'(ey), (ex < 640 && ey < 480), exp_hs, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL sync_timing: x=%0d y=%0d vde=%b hs=%b vs=%b vb=%b, want x=%0d y=%0d hs=%b vs=1 vb=0",
                 drawX, drawY, vde, hsync, vsync, vblank_start, ex, ey, exp_hs);
      end
      if (prev_hs && !hsync) begin
        if (last_fall >= 0) begin
          n_cmp++;
          if (c - last_fall != 800) begin
            n_bad++;
            $display("FAIL hsync_period: got %0d want 800", c - last_fall);
          end
        end
        last_fall = c;
      end
      prev_hs = hsync;
    end
  endtask

  task automatic test_random_palette();
    bit ok;
    logic [11:0] exp;
    for (int y = 4; y < 32; y++) begin
      wait_pix(700, y - 1, ok);
      pal_write(4'($urandom_range(0, 15)), 12'($urandom));
      wait_pix(0, y, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rand_line_wait: line %0d never started", y);
        return;
      end
      for (int x = 0; x < 640; x++) begin
        if (x > 0) @(negedge pixel_clk);
        exp = model_rgb(x, y);
        n_cmp++;
        if ({vde, drawX, drawY, red, green, blue} !== {1'b1, 10'(x), 10'(y), exp}) begin
          n_bad++;
          $display("FAIL rand_pixel: x=%0d y=%0d vde=%b rgb=%h want (%0d,%0d) rgb=%h",
                   drawX, drawY, vde, {red, green, blue}, x, y, exp);
        end
      end
    end
  endtask

  task automatic test_tile_fetch();
    bit ok;
    int px;
    logic [15:0] exp_ra;
    wait_pix(700, 31, ok);
    pal_write(4'd5, 12'hF80);
    for (int y = 32; y < 36; y++) begin
      wait_pix(0, y, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL tile_line_wait: line %0d never started", y);
        return;
      end
      for (int x = 0; x < 640; x++) begin
        if (x > 0) @(negedge pixel_clk);
        n_cmp++;
        if ({drawX, red, green, blue} !== {10'(x), model_rgb(x, y)}) begin
          n_bad++;
          $display("FAIL tile_pixel: x=%0d y=%0d rgb=%h want rgb=%h", drawX, y, {red, green, blue}, model_rgb(x, y));
        end
        if (x >= 32 && x < 64) begin
          n_cmp++;
          if ({red, green, blue} !== 12'hF80) begin
            n_bad++;
            $display("FAIL tile_color: x=%0d y=%0d rgb=%h want F80", x, y, {red, green, blue});
          end
        end
        px = x + 2;
        if (px >= 32 && px < 64) begin
          exp_ra = {6'd3, 5'(y % 32), 5'(px % 32)};
          n_cmp++;
          if (mem_if.rom_addr !== exp_ra) begin
            n_bad++;
            $display("FAIL tile_rom_addr: px=%0d y=%0d rom_addr=%h want %h", px, y, mem_if.rom_addr, exp_ra);
          end
        end
      end
    end
  endtask

  task automatic test_hflip_hide();
    bit ok;
    int px;
    logic [15:0] exp_ra;
    for (int y = 36; y < 40; y++) begin
      wait_pix(0, y, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL flip_line_wait: line %0d never started", y);
        return;
      end
      for (int x = 0; x < 640; x++) begin
        if (x > 0) @(negedge pixel_clk);
        n_cmp++;
        if ({drawX, red, green, blue} !== {10'(x), model_rgb(x, y)}) begin
          n_bad++;
          $display("FAIL flip_pixel: x=%0d y=%0d rgb=%h want rgb=%h", drawX, y, {red, green, blue}, model_rgb(x, y));
        end
        if (x >= 128 && x < 192) begin
          n_cmp++;
          if ({red, green, blue} !== 12'h00F) begin
            n_bad++;
            $display("FAIL hide_or_zero_bg: x=%0d y=%0d rgb=%h want 00F", x, y, {red, green, blue});
          end
        end
        px = x + 2;
        if (px >= 64 && px < 96) begin
          exp_ra = {6'd3, 5'(y % 32), 5'(31 - (px % 32))};
          n_cmp++;
          if (mem_if.rom_addr !== exp_ra) begin
            n_bad++;
            $display("FAIL hflip_rom_addr: px=%0d y=%0d rom_addr=%h want %h", px, y, mem_if.rom_addr, exp_ra);
          end
        end
      end
    end
  endtask

  task automatic test_palette_collision();
    bit ok;
    wait_pix(38, 40, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL collide_wait: pixel (38,40) never seen");
      return;
    end
    pal_idx  = 4'd5;
    pal_data = 12'h0F0;
    pal_we   = 1'b1;
    @(posedge pixel_clk);
    #1 pal_we = 1'b0;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    n_cmp++;
    if ({drawX, red, green, blue} !== {10'd40, 12'hF80}) begin
      n_bad++;
      $display("FAIL collide_old: x=%0d rgb=%h want x=40 rgb=F80", drawX, {red, green, blue});
    end
    @(negedge pixel_clk);
    n_cmp++;
    if ({drawX, red, green, blue} !== {10'd41, 12'h0F0}) begin
      n_bad++;
      $display("FAIL collide_new: x=%0d rgb=%h want x=41 rgb=0F0", drawX, {red, green, blue});
    end
    pal_m[5] = 12'h0F0;
    for (int x = 42; x < 640; x++) begin
      @(negedge pixel_clk);
      n_cmp++;
      if ({drawX, red, green, blue} !== {10'(x), model_rgb(x, 40)}) begin
        n_bad++;
        $display("FAIL collide_tail: x=%0d rgb=%h want x=%0d rgb=%h", drawX, {red, green, blue}, x, model_rgb(x, 40));
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    // Output at (296,41) means the raster counter is at hc=300 on line 41.
    wait_pix(296, 41, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL midreset_wait: pixel (296,41) never seen");
      return;
    end
    arstn = 1'b0;
    @(posedge pixel_clk);
    #1 arstn = 1'b1;
    pal_reset_model();
    for (int k = 0; k < 5; k++) begin
      @(negedge pixel_clk);
      n_cmp++;
      if ({vde, red, green, blue} !== 13'd0) begin
        n_bad++;
        $display("FAIL midreset_quiet: cycle %0d vde=%b rgb=%h want vde=0 rgb=000", k, vde, {red, green, blue});
      end
    end
    for (int x = 0; x < 640; x++) begin
      @(negedge pixel_clk);
      n_cmp++;
      if ({vde, drawX, drawY, red, green, blue} !== {1'b1, 10'(x), 10'd0, model_rgb(x, 0)}) begin
        n_bad++;
        $display("FAIL midreset_resume: vde=%b x=%0d y=%0d rgb=%h want vde=1 x=%0d y=0 rgb=%h",
                 vde, drawX, drawY, {red, green, blue}, x, model_rgb(x, 0));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) map_mem[i] = 8'($urandom);
    for (int i = 0; i < 65536; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 1024; i++) begin
      rom_mem[0 * 1024 + i] = 4'd0;
      rom_mem[1 * 1024 + i] = 4'd7;
      rom_mem[3 * 1024 + i] = 4'd5;
    end
    map_mem[0]  = 8'h01;
    map_mem[21] = 8'h03;
    map_mem[22] = 8'h43;
    map_mem[23] = 8'h44;
    map_mem[24] = 8'h83;
    map_mem[25] = 8'h00;

    test_reset();
    test_sync();
    test_random_palette();
    test_tile_fetch();
    test_hflip_hide();
    test_palette_collision();
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
